calculator: RTL and testbench

CALCULATOR -- requirements
Module: calculator

---
 rtl/calculator.sv | 102 ++++++++++
 tb/tb_calculator.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/calculator.sv
// calculator: 3x3 unsigned matrix multiply C = A*B, one element per cycle.
// Define CALC_SATURATE_EN to clamp elements at 2^RES_W-1 instead of wrapping.
module calculator #(
    parameter int DATA_W = 8,
    parameter int RES_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable_multiplication,
    input  logic [9*DATA_W-1:0]  A,
    input  logic [9*DATA_W-1:0]  B,
    output logic [9*RES_W-1:0]   result,
    output logic                 mult_done
);
    localparam int SUM_W = 2*DATA_W + 2;

    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

    state_t                state_q, state_d;
    logic [9*DATA_W-1:0]   a_q, a_d, b_q, b_d;
    logic [3:0]            idx_q, idx_d;
    logic [9*RES_W-1:0]    work_q, work_d, result_q, result_d;
    logic                  done_q, done_d;
    logic [3:0]            row, col;
    logic [SUM_W-1:0]      sum;
    logic [RES_W-1:0]      elem;

    assign row       = idx_q / 4'd3;
    assign col       = idx_q % 4'd3;
    assign result    = result_q;
    assign mult_done = done_q;

    // Full-width dot product of row `row` of A with column `col` of B
    always_comb begin
        sum = '0;
        for (int m = 0; m < 3; m++)
            sum = sum + SUM_W'(a_q[(row*3+m)*DATA_W +: DATA_W]) * SUM_W'(b_q[(m*3+col)*DATA_W +: DATA_W]);
    end

`ifdef CALC_SATURATE_EN
    assign elem = (sum >> RES_W) != '0 ? {RES_W{1'b1}} : RES_W'(sum);
`else
    assign elem = RES_W'(sum);
`endif

    // Next-state and datapath updates; result only moves on the element-8 write
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        idx_d    = idx_q;
        work_d   = work_q;
        result_d = result_q;
        done_d   = done_q;
        case (state_q)
            IDLE: if (enable_multiplication) begin
                a_d     = A;
                b_d     = B;
                idx_d   = '0;
                state_d = COMPUTE;
            end
            COMPUTE: if (!enable_multiplication) begin
                state_d = IDLE;
            end else begin
                work_d[idx_q*RES_W +: RES_W] = elem;
                if (idx_q == 4'd8) begin
                    result_d = work_d;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            DONE: if (!enable_multiplication) begin
                state_d = IDLE;
                done_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            idx_q    <= '0;
            work_q   <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            idx_q    <= idx_d;
            work_q   <= work_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end
endmodule

// File: tb/tb_calculator.sv
// tb_calculator: randomized and directed checks of calculator against a matrix reference model.
module tb_calculator;
    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en  = 1'b0;
    logic [71:0]   a_bus = '0, b_bus = '0;
    logic [143:0]  result;
    logic          mult_done;
    int            n_cmp = 0, n_err = 0;
    int unsigned   ma[9], mb[9], me[9];
    logic [143:0]  saved;

    calculator dut (
        .clk(clk), .rst(rst), .enable_multiplication(en),
        .A(a_bus), .B(b_bus), .result(result), .mult_done(mult_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [71:0] pk8(input int unsigned v[9]);
        logic [71:0] r = '0;
        for (int k = 0; k < 9; k++) r[k*8 +: 8] = v[k][7:0];
        return r;
    endfunction

    function automatic logic [143:0] pk16(input int unsigned v[9]);
        logic [143:0] r = '0;
        for (int k = 0; k < 9; k++) r[k*16 +: 16] = v[k][15:0];
        return r;
    endfunction

    function automatic logic [143:0] model(input int unsigned a[9], input int unsigned b[9]);
        int unsigned c[9];
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                longint unsigned s = 0;
                for (int m = 0; m < 3; m++) s += longint'(a[3*i+m]) * longint'(b[3*m+j]);
`ifdef CALC_SATURATE_EN
                c[3*i+j] = s > 65535 ? 65535 : int'(s);
`else
                c[3*i+j] = int'(s % 65536);
`endif
            end
        return pk16(c);
    endfunction

    task automatic randomize_mats();
        for (int k = 0; k < 9; k++) begin
            ma[k] = $urandom_range(255);
            mb[k] = $urandom_range(255);
        end
    endtask

    // Start with ma/mb, scramble inputs after the start edge, check latency, hold and result, then release
    task automatic run(input string tag);
        logic [143:0] prev = result;
        logic [143:0] exp  = model(ma, mb);
        int edges = 0;
        a_bus = pk8(ma);
        b_bus = pk8(mb);
        en = 1'b1;
        while (!mult_done && edges < 30) begin
            tick();
            edges++;
            a_bus = 72'({$urandom(), $urandom(), $urandom()});
            b_bus = 72'({$urandom(), $urandom(), $urandom()});
            if (!mult_done) chk({tag, "_hold"}, result, prev);
        end
        chk({tag, "_latency"}, 144'(edges), 144'(10));
        chk({tag, "_result"}, result, exp);
        en = 1'b0;
        tick();
        chk({tag, "_done_clr"}, 144'(mult_done), 144'(0));
        chk({tag, "_retain"}, result, exp);
    endtask

    initial begin
        #3;
        chk("reset_result", result, '0);
        chk("reset_done", 144'(mult_done), 144'(0));
        #5 rst = 1'b1;
        tick();

        for (int k = 0; k < 9; k++) begin
            ma[k] = (k % 4 == 0) ? 1 : 0;
            mb[k] = k + 1;
        end
        run("identity");
        chk("identity_is_b", result, pk16(mb));

        for (int k = 0; k < 9; k++) begin
            ma[k] = k + 1;
            mb[k] = 9 - k;
        end
        me = '{30, 24, 18, 84, 69, 54, 138, 114, 90};
        run("seq");
        chk("seq_const", result, pk16(me));

        for (int k = 0; k < 9; k++) begin
            ma[k] = 255;
            mb[k] = 255;
        end
        run("max");
`ifdef CALC_SATURATE_EN
        chk("max_const", result, {9{16'hFFFF}});
`else
        chk("max_const", result, {9{16'hFA03}});
`endif

        saved = result;
        randomize_mats();
        a_bus = pk8(ma);
        b_bus = pk8(mb);
        en = 1'b1;
        tick();
        for (int e = 1; e <= 3; e++) tick();
        en = 1'b0;
        for (int e = 0; e < 12; e++) begin
            tick();
            chk("abort_done", 144'(mult_done), 144'(0));
            chk("abort_result", result, saved);
        end
        run("restart");

        for (int r = 0; r < 8; r++) begin
            randomize_mats();
            run("rand");
        end

        randomize_mats();
        a_bus = pk8(ma);
        b_bus = pk8(mb);
        en = 1'b1;
        for (int e = 0; e < 10; e++) tick();
        chk("hold_done_rise", 144'(mult_done), 144'(1));
        saved = model(ma, mb);
        for (int e = 0; e < 20; e++) begin
            a_bus = 72'({$urandom(), $urandom(), $urandom()});
            tick();
            chk("hold_done", 144'(mult_done), 144'(1));
            chk("hold_result", result, saved);
        end
        en = 1'b0;
        tick();
        chk("hold_release", 144'(mult_done), 144'(0));
        chk("hold_retain", result, saved);

        randomize_mats();
        a_bus = pk8(ma);
        b_bus = pk8(mb);
        en = 1'b1;
        for (int e = 0; e < 5; e++) tick();
        #2 rst = 1'b0;
        #1;
        chk("rst_compute_result", result, '0);
        chk("rst_compute_done", 144'(mult_done), 144'(0));
        en = 1'b0;
        #1 rst = 1'b1;
        tick();
        chk("rst_stays_idle", 144'(mult_done), 144'(0));

        randomize_mats();
        run("post_rst");

        a_bus = pk8(ma);
        b_bus = pk8(mb);
        en = 1'b1;
        for (int e = 0; e < 10; e++) tick();
        chk("rst_done_pre", 144'(mult_done), 144'(1));
        #2 rst = 1'b0;
        #1;
        chk("rst_done_result", result, '0);
        chk("rst_done_done", 144'(mult_done), 144'(0));
        en = 1'b0;
        #1 rst = 1'b1;
        tick();

        randomize_mats();
        run("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
